fft_mem_ctl: RTL
================

Name: fft_mem_ctl

Overview:
- Sequencer that masters the 8x8 FFT register-manager interface for one 64-point base-8 FFT frame.
- Loads 64 serial samples through the 1x1 write port, then runs two 8-line butterfly passes through the 1x8 read/write ports and an external fft8 butterfly engine.
- Finally streams the 64 results out through the 1x1 read port.
- Sits between the sample stream interface and the register manager / butterfly datapath.

Parameters:
DATA_WD  32  width of one complex sample (re/im packed)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  frame start pulse, accepted only in IDLE
dat_val_i  input  1  input sample valid (LOAD only)
dat_i  input  DATA_WD  input sample
dat_val_o  output  1  output sample valid
dat_o  output  DATA_WD  output sample
busy_o  output  1  high from start accept until done
done_o  output  1  one-cycle pulse after the last output sample
dim_1x8_o  output  1  1x8 dimension: 1 = 8 cells sharing adr_y=adr, 0 = 8 cells sharing adr_x=adr
adr_1x8_o  output  3  1x8 line address (shared by read and write)
rd_val_1x8_o  output  1  1x8 read request
rd_val_1x8_i  input  1  1x8 read data valid (1 cycle after request)
rd_dat_1x8_i  input  8*DATA_WD  1x8 read data, element 0 in the LSBs
wr_val_1x8_o  output  1  1x8 write strobe
wr_dat_1x8_o  output  8*DATA_WD  1x8 write data
adr_x_1x1_o  output  3  1x1 x address
adr_y_1x1_o  output  3  1x1 y address
rd_val_1x1_o  output  1  1x1 read request
rd_val_1x1_i  input  1  1x1 read data valid (1 cycle after request)
rd_dat_1x1_i  input  DATA_WD  1x1 read data
wr_val_1x1_o  output  1  1x1 write strobe
wr_dat_1x1_o  output  DATA_WD  1x1 write data
bfy_val_o  output  1  line valid to butterfly engine (one-cycle pulse)
bfy_dat_o  output  8*DATA_WD  line data to engine
bfy_pass_o  output  1  pass index (0/1)
bfy_idx_o  output  3  line index within pass
bfy_val_i  input  1  engine result valid (any latency >= 1)
bfy_dat_i  input  8*DATA_WD  engine result

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0. Reset mid-frame aborts immediately with no done_o.
- FSM states: IDLE -> LOAD -> P0_RD -> P0_WT -> P1_RD -> P1_WT -> DUMP -> DONE -> IDLE.
- IDLE: start_i=1 -> LOAD; busy_o=1 from the next cycle. start_i outside IDLE is ignored.
- LOAD:
  - Each dat_val_i=1 cycle drives wr_val_1x1_o=1 combinationally, with adr_x=n[2:0], adr_y=n[5:3] and wr_dat_1x1_o=dat_i, where n is the 6-bit sample counter.
  - n=63 accepted -> P0_RD. Gaps in dat_val_i are allowed.
- Px_RD:
  - Drive rd_val_1x8_o=1 for one cycle with adr_1x8_o=line.
  - dim_1x8_o: pass0 = 0, pass1 = 1.
  - Go to Px_WT.
- Px_WT:
  - The cycle rd_val_1x8_i=1: bfy_val_o=1, bfy_dat_o=rd_dat_1x8_i, bfy_pass_o=pass, bfy_idx_o=line.
  - The cycle bfy_val_i=1: wr_val_1x8_o=1, wr_dat_1x8_o=bfy_dat_i, same dim and adr.
  - Then line+1, back to Px_RD. After line 7 go to the next pass or DUMP.
  - bfy_val_i outside Px_WT is ignored.
  - dim/adr stay stable from read request through write-back.
  - Only one line is ever outstanding.
- DUMP:
  - Issue rd_val_1x1_o=1 every cycle for 64 cycles, counter m = 0..63.
  - dat_val_o=rd_val_1x1_i and dat_o=rd_dat_1x1_i, passed through.
  - The last request is followed by 1 cycle for the last data, then DONE.
- DONE: done_o=1 for one cycle, busy_o=0, go to IDLE.
- Never asserts 1x1 and 1x8 strobes, or read and write strobes, in the same cycle.
- Counters wrap at their natural width only through explicit state change; no wrap inside a state.

Optional Feature:
FFT_CTL_DIGITREV_EN
- Defined: DUMP uses adr_x=m[5:3], adr_y=m[2:0], so the output is in natural frequency order.
- Undefined: DUMP uses adr_x=m[2:0], adr_y=m[5:3], so the output is in raw digit-reversed order.

Test Plan:
- Reset with rst_n=0 mid-P0_WT -> all strobes 0 and busy_o=0 immediately; the next start_i runs a full frame normally.
- start_i, then 64 samples value=n with no gaps -> wr_val_1x1_o 64 times; sample 10 written to x=2, y=1; FSM enters P0_RD one cycle after the last sample.
- Identity engine, bfy_val_i 1 cycle after bfy_val_o -> 16 line reads/writes: pass0 dim=0 adr 0..7, then pass1 dim=1 adr 0..7; the output stream equals the input in dump order.
- Engine latency 5 with dat_val_i gaps of 3 cycles -> same results; exactly one rd_val_1x8_o per line; no request issued while waiting.
- Engine adding 1 to every element -> every output equals input+2; done_o pulses once, one cycle after the 64th dat_val_o.
- Macro on, identity engine, input n -> output index m yields value (m[2:0]<<3)|m[5:3]; macro off -> output m yields value m.

Source files
------------

// File: rtl/fft_mem_ctl_if.sv
// Register-manager bus of the 64-point FFT sequencer.
// Carries the 1x8 line port (read/write, shared line address) and the
// 1x1 cell port (read/write, x/y address). Signal suffixes are as seen
// from the sequencer: *_o driven by the master, *_i returned by the slave.
interface fft_mem_ctl_if #(
  parameter int DATA_WD = 32
);
  // 1x8 line port
  logic                   dim_1x8_o;
  logic [2:0]             adr_1x8_o;
  logic                   rd_val_1x8_o;
  logic                   rd_val_1x8_i;
  logic [8*DATA_WD-1:0]   rd_dat_1x8_i;
  logic                   wr_val_1x8_o;
  logic [8*DATA_WD-1:0]   wr_dat_1x8_o;

  // 1x1 cell port
  logic [2:0]             adr_x_1x1_o;
  logic [2:0]             adr_y_1x1_o;
  logic                   rd_val_1x1_o;
  logic                   rd_val_1x1_i;
  logic [DATA_WD-1:0]     rd_dat_1x1_i;
  logic                   wr_val_1x1_o;
  logic [DATA_WD-1:0]     wr_dat_1x1_o;

  // Sequencer side
  modport master (
    output dim_1x8_o, adr_1x8_o, rd_val_1x8_o, wr_val_1x8_o, wr_dat_1x8_o,
    input  rd_val_1x8_i, rd_dat_1x8_i,
    output adr_x_1x1_o, adr_y_1x1_o, rd_val_1x1_o, wr_val_1x1_o, wr_dat_1x1_o,
    input  rd_val_1x1_i, rd_dat_1x1_i
  );

  // Register-manager side
  modport slave (
    input  dim_1x8_o, adr_1x8_o, rd_val_1x8_o, wr_val_1x8_o, wr_dat_1x8_o,
    output rd_val_1x8_i, rd_dat_1x8_i,
    input  adr_x_1x1_o, adr_y_1x1_o, rd_val_1x1_o, wr_val_1x1_o, wr_dat_1x1_o,
    output rd_val_1x1_i, rd_dat_1x1_i
  );
endinterface

// File: rtl/fft_mem_ctl.sv
// fft_mem_ctl: frame sequencer for a 64-point base-8 FFT.
// Loads 64 samples into the 8x8 register manager over the 1x1 port, runs
// two passes of eight line butterflies (pass 0 on columns, pass 1 on rows)
// through the 1x8 port and an external fft8 engine, then streams the 64
// results back out over the 1x1 port.
// Optional feature macro: FFT_CTL_DIGITREV_EN
//   defined   -> results leave in natural frequency order
//   undefined -> results leave in raw digit-reversed order
module fft_mem_ctl #(
  parameter int DATA_WD = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,

  // Sample stream
  input  logic                 start_i,
  input  logic                 dat_val_i,
  input  logic [DATA_WD-1:0]   dat_i,
  output logic                 dat_val_o,
  output logic [DATA_WD-1:0]   dat_o,
  output logic                 busy_o,
  output logic                 done_o,

  // Register manager
  fft_mem_ctl_if.master        mem,

  // Butterfly engine
  output logic                 bfy_val_o,
  output logic [8*DATA_WD-1:0] bfy_dat_o,
  output logic                 bfy_pass_o,
  output logic [2:0]           bfy_idx_o,
  input  logic                 bfy_val_i,
  input  logic [8*DATA_WD-1:0] bfy_dat_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_P0_RD = 3'd2,
    ST_P0_WT = 3'd3,
    ST_P1_RD = 3'd4,
    ST_P1_WT = 3'd5,
    ST_DUMP  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam logic [5:0] CNT_LAST  = 6'd63;
  localparam logic [2:0] LINE_LAST = 3'd7;

  state_t       state_r, state_s;
  logic [5:0]   cnt_r,   cnt_s;    // sample index n in LOAD, output index m in DUMP
  logic [2:0]   line_r,  line_s;   // line within the current pass
  logic         sent_r,  sent_s;   // current line handed to the engine, awaiting result
  logic         tail_r,  tail_s;   // DUMP: all 64 requests issued, last data in flight
  logic [5:0]   dump_xy_s;         // {y, x} cell address used while dumping

  // Cell visited for output index m; returns {adr_y, adr_x}.
  function automatic logic [5:0] dump_xy(input logic [5:0] m);
`ifdef FFT_CTL_DIGITREV_EN
    // x = m[5:3], y = m[2:0]: transposed read gives natural order
    return {m[2:0], m[5:3]};
`else
    // x = m[2:0], y = m[5:3]: same mapping as the load, digit-reversed order
    return m;
`endif
  endfunction

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      line_r  <= 3'd0;
      sent_r  <= 1'b0;
      tail_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      line_r  <= line_s;
      sent_r  <= sent_s;
      tail_r  <= tail_s;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    line_s  = line_r;
    sent_s  = sent_r;
    tail_s  = tail_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_LOAD;
          cnt_s   = 6'd0;
          line_s  = 3'd0;
          sent_s  = 1'b0;
          tail_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (dat_val_i) begin
          if (cnt_r == CNT_LAST) begin
            state_s = ST_P0_RD;
            cnt_s   = 6'd0;
          end else begin
            cnt_s   = cnt_r + 6'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_P0_RD: begin
        state_s = ST_P0_WT;
        sent_s  = 1'b0;
      end
      ST_P1_RD: begin
        state_s = ST_P1_WT;
        sent_s  = 1'b0;
      end
      ST_P0_WT, ST_P1_WT: begin
        if (!sent_r) begin
          // waiting for the line to come back from the register manager
          if (mem.rd_val_1x8_i) begin
            sent_s = 1'b1;
          end else begin
            sent_s = 1'b0;
          end
        end else if (bfy_val_i) begin
          // engine result written back this cycle; move to the next line
          sent_s = 1'b0;
          if (line_r == LINE_LAST) begin
            line_s  = 3'd0;
            state_s = (state_r == ST_P0_WT) ? ST_P1_RD : ST_DUMP;
            cnt_s   = 6'd0;
            tail_s  = 1'b0;
          end else begin
            line_s  = line_r + 3'd1;
            state_s = (state_r == ST_P0_WT) ? ST_P0_RD : ST_P1_RD;
          end
        end else begin
          sent_s = sent_r;
        end
      end
      ST_DUMP: begin
        if (!tail_r) begin
          if (cnt_r == CNT_LAST) begin
            tail_s = 1'b1;
            cnt_s  = 6'd0;
          end else begin
            cnt_s  = cnt_r + 6'd1;
          end
        end else begin
          // one extra cycle lets the last read data pass through
          tail_s  = 1'b0;
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 6'd0;
        line_s  = 3'd0;
        sent_s  = 1'b0;
        tail_s  = 1'b0;
      end
    endcase
  end

  assign dump_xy_s = dump_xy(cnt_r);

  // Bus, engine and stream outputs decoded from state and returning data
  always_comb begin
    mem.dim_1x8_o    = 1'b0;
    mem.adr_1x8_o    = 3'd0;
    mem.rd_val_1x8_o = 1'b0;
    mem.wr_val_1x8_o = 1'b0;
    mem.wr_dat_1x8_o = '0;
    mem.adr_x_1x1_o  = 3'd0;
    mem.adr_y_1x1_o  = 3'd0;
    mem.rd_val_1x1_o = 1'b0;
    mem.wr_val_1x1_o = 1'b0;
    mem.wr_dat_1x1_o = '0;
    bfy_val_o        = 1'b0;
    bfy_dat_o        = '0;
    bfy_pass_o       = 1'b0;
    bfy_idx_o        = 3'd0;
    dat_val_o        = 1'b0;
    dat_o            = '0;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      ST_LOAD: begin
        busy_o = 1'b1;
        if (dat_val_i) begin
          mem.wr_val_1x1_o = 1'b1;
          mem.adr_x_1x1_o  = cnt_r[2:0];
          mem.adr_y_1x1_o  = cnt_r[5:3];
          mem.wr_dat_1x1_o = dat_i;
        end else begin
          mem.wr_val_1x1_o = 1'b0;
        end
      end
      ST_P0_RD, ST_P1_RD: begin
        busy_o           = 1'b1;
        mem.dim_1x8_o    = (state_r == ST_P1_RD);
        mem.adr_1x8_o    = line_r;
        mem.rd_val_1x8_o = 1'b1;
        bfy_pass_o       = (state_r == ST_P1_RD);
        bfy_idx_o        = line_r;
      end
      ST_P0_WT, ST_P1_WT: begin
        // dim/adr held from the read request through the write-back
        busy_o        = 1'b1;
        mem.dim_1x8_o = (state_r == ST_P1_WT);
        mem.adr_1x8_o = line_r;
        bfy_pass_o    = (state_r == ST_P1_WT);
        bfy_idx_o     = line_r;
        if (!sent_r && mem.rd_val_1x8_i) begin
          bfy_val_o = 1'b1;
          bfy_dat_o = mem.rd_dat_1x8_i;
        end else if (sent_r && bfy_val_i) begin
          mem.wr_val_1x8_o = 1'b1;
          mem.wr_dat_1x8_o = bfy_dat_i;
        end else begin
          bfy_val_o = 1'b0;
        end
      end
      ST_DUMP: begin
        busy_o = 1'b1;
        if (!tail_r) begin
          mem.rd_val_1x1_o = 1'b1;
          mem.adr_x_1x1_o  = dump_xy_s[2:0];
          mem.adr_y_1x1_o  = dump_xy_s[5:3];
        end else begin
          mem.rd_val_1x1_o = 1'b0;
        end
        if (mem.rd_val_1x1_i) begin
          dat_val_o = 1'b1;
          dat_o     = mem.rd_dat_1x1_i;
        end else begin
          dat_val_o = 1'b0;
        end
      end
      ST_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule
